// File: rtl/raspi_command_sequencer.sv
// Decodes execute/jam/processor-reset frames from the Pi byte link and drives the processor.
// Optional: define FRAME_TIMEOUT_EN to abort frames that stall mid-way for TIMEOUT_CYCLES cycles.
module raspi_command_sequencer #(
    parameter int GO_CYCLES      = 4,
    parameter int RESULT_WAIT    = 64,
    parameter int PULSE_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       SYSTEM_CLK,
    input  logic       RESET_BAR,
    input  logic [7:0] RX_BYTE,
    input  logic       RX_VALID,
    output logic       RX_READY,
    output logic [3:0] OPCODE,
    output logic [7:0] DATA_IN_A,
    output logic [7:0] DATA_IN_B,
    output logic       GO,
    output logic       JAM,
    output logic       PROC_RESET,
    input  logic [7:0] PROC_DATA_OUT,
    output logic [7:0] RESULT,
    output logic       RESULT_VALID,
    input  logic       RESULT_ACK,
    output logic       BUSY,
    output logic       FRAME_ERR
);

    // One shared down-counter width that fits the largest configured interval.
    localparam int MAX_GP  = (GO_CYCLES > PULSE_CYCLES) ? GO_CYCLES : PULSE_CYCLES;
    localparam int MAX_GPW = (MAX_GP > RESULT_WAIT) ? MAX_GP : RESULT_WAIT;
    localparam int MAX_ALL = (MAX_GPW > TIMEOUT_CYCLES) ? MAX_GPW : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] GO_LOAD    = CNT_W'(GO_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(RESULT_WAIT - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_A,
        ST_GET_B,
        ST_GO_HI,
        ST_WAIT,
        ST_RESULT,
        ST_PULSE
    } state_t;

    typedef enum logic [1:0] {
        CMD_EXEC = 2'b00,
        CMD_JAM  = 2'b01,
        CMD_RST  = 2'b10,
        CMD_ILL  = 2'b11
    } cmd_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       op_lat_q;
    logic [7:0]       a_lat_q;
    logic [3:0]       opcode_q;
    logic [7:0]       data_a_q;
    logic [7:0]       data_b_q;
    logic             go_q;
    logic             jam_q;
    logic             prst_q;
    logic [7:0]       result_q;
    logic             result_valid_q;
    logic             frame_err_q;
    logic             rx_ready_q;

    logic accept;
    cmd_t hdr_cmd;
    logic unused_hdr_bits;

    assign accept  = RX_VALID && rx_ready_q;
    assign hdr_cmd = cmd_t'(RX_BYTE[7:6]);
    // Header bits [5:4] are reserved.
    assign unused_hdr_bits = ^RX_BYTE[5:4];

`ifdef FRAME_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] to_cnt_q;
`endif

    always_ff @(posedge SYSTEM_CLK or negedge RESET_BAR) begin
        if (!RESET_BAR) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            op_lat_q       <= '0;
            a_lat_q        <= '0;
            opcode_q       <= '0;
            data_a_q       <= '0;
            data_b_q       <= '0;
            go_q           <= 1'b0;
            jam_q          <= 1'b0;
            prst_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            rx_ready_q     <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            to_cnt_q       <= '0;
`endif
        end else begin
            // NOTE: a default non-blocking assignment at the top makes FRAME_ERR a one-cycle
            // pulse; any later assignment in this block to the same register takes precedence.
            frame_err_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    rx_ready_q <= 1'b1;
                    if (accept) begin
                        case (hdr_cmd)
                            CMD_EXEC: begin
                                op_lat_q <= RX_BYTE[3:0];
                                state_q  <= ST_GET_A;
                            end
                            CMD_JAM: begin
                                jam_q      <= 1'b1;
                                cnt_q      <= PULSE_LOAD;
                                rx_ready_q <= 1'b0;
                                state_q    <= ST_PULSE;
                            end
                            CMD_RST: begin
                                prst_q     <= 1'b1;
                                cnt_q      <= PULSE_LOAD;
                                rx_ready_q <= 1'b0;
                                state_q    <= ST_PULSE;
                            end
                            CMD_ILL: frame_err_q <= 1'b1;
                            default: frame_err_q <= 1'b1;
                        endcase
                    end
                end

                ST_GET_A: begin
                    if (accept) begin
                        a_lat_q <= RX_BYTE;
                        state_q <= ST_GET_B;
                    end
                end

                // Processor operands change only here, all on the B-accept edge.
                ST_GET_B: begin
                    if (accept) begin
                        opcode_q   <= op_lat_q;
                        data_a_q   <= a_lat_q;
                        data_b_q   <= RX_BYTE;
                        go_q       <= 1'b1;
                        cnt_q      <= GO_LOAD;
                        rx_ready_q <= 1'b0;
                        state_q    <= ST_GO_HI;
                    end
                end

                ST_GO_HI: begin
                    if (cnt_q == '0) begin
                        go_q    <= 1'b0;
                        cnt_q   <= WAIT_LOAD;
                        state_q <= ST_WAIT;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        result_q       <= PROC_DATA_OUT;
                        result_valid_q <= 1'b1;
                        state_q        <= ST_RESULT;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                ST_RESULT: begin
                    if (RESULT_ACK) begin
                        result_valid_q <= 1'b0;
                        rx_ready_q     <= 1'b1;
                        state_q        <= ST_IDLE;
                    end
                end

                ST_PULSE: begin
                    if (cnt_q == '0) begin
                        jam_q      <= 1'b0;
                        prst_q     <= 1'b0;
                        rx_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                default: begin
                    rx_ready_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
            endcase

`ifdef FRAME_TIMEOUT_EN
            // A stalled frame is dropped; latched header/A never reach the processor.
            if ((state_q == ST_GET_A || state_q == ST_GET_B) && !accept) begin
                if (to_cnt_q == TO_LAST) begin
                    to_cnt_q    <= '0;
                    state_q     <= ST_IDLE;
                    frame_err_q <= 1'b1;
                end else begin
                    to_cnt_q <= to_cnt_q + CNT_ONE;
                end
            end else begin
                to_cnt_q <= '0;
            end
`endif
        end
    end

    assign RX_READY     = rx_ready_q;
    assign OPCODE       = opcode_q;
    assign DATA_IN_A    = data_a_q;
    assign DATA_IN_B    = data_b_q;
    assign GO           = go_q;
    assign JAM          = jam_q;
    assign PROC_RESET   = prst_q;
    assign RESULT       = result_q;
    assign RESULT_VALID = result_valid_q;
    assign BUSY         = (state_q != ST_IDLE);
    assign FRAME_ERR    = frame_err_q;

endmodule

// File: tb/tb_raspi_command_sequencer.sv
// Directed bench for raspi_command_sequencer; the timeout scenario runs only with FRAME_TIMEOUT_EN.
module tb_raspi_command_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_byte = '0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [3:0] opcode;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic       go;
    logic       jam;
    logic       proc_reset;
    logic [7:0] proc_data_out = '0;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ack = 1'b0;
    logic       busy;
    logic       frame_err;

    int checks = 0;
    int passed = 0;

    raspi_command_sequencer #(
        .GO_CYCLES     (4),
        .RESULT_WAIT   (64),
        .PULSE_CYCLES  (2),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .SYSTEM_CLK   (clk),
        .RESET_BAR    (rst_n),
        .RX_BYTE      (rx_byte),
        .RX_VALID     (rx_valid),
        .RX_READY     (rx_ready),
        .OPCODE       (opcode),
        .DATA_IN_A    (data_a),
        .DATA_IN_B    (data_b),
        .GO           (go),
        .JAM          (jam),
        .PROC_RESET   (proc_reset),
        .PROC_DATA_OUT(proc_data_out),
        .RESULT       (result),
        .RESULT_VALID (result_valid),
        .RESULT_ACK   (result_ack),
        .BUSY         (busy),
        .FRAME_ERR    (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one byte and returns one step after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_byte  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (rx_ready !== 1'b1) $display("FAIL send_ready_%02h: got rx_ready=%0b want 1", b, rx_ready);
        else passed++;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        checks++;
        if ({rx_ready, opcode, data_a, data_b, go, jam, proc_reset, result, result_valid, busy, frame_err} !== 35'd0)
            $display("FAIL reset_outputs: got rdy=%0b op=%h a=%h b=%h go=%0b jam=%0b prst=%0b res=%h rv=%0b busy=%0b ferr=%0b want all 0",
                     rx_ready, opcode, data_a, data_b, go, jam, proc_reset, result, result_valid, busy, frame_err);
        else passed++;
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({rx_ready, busy} !== 2'b10) $display("FAIL reset_idle: got rdy=%0b busy=%0b want 1 0", rx_ready, busy);
        else passed++;
    endtask

    // Execute 0x03/0x5A/0x21, result 0x7B, then the Pi stalls a header byte 0x00 behind the result.
    task automatic test_execute_backpressure();
        int n;
        proc_data_out = 8'h7B;
        send_byte(8'h03);
        checks++;
        if ({busy, rx_ready, go} !== 3'b110) $display("FAIL exec_get_a: got busy=%0b rdy=%0b go=%0b want 1 1 0", busy, rx_ready, go);
        else passed++;
        send_byte(8'h5A);
        checks++;
        if ({opcode, data_a, go} !== {4'h0, 8'h00, 1'b0}) $display("FAIL exec_early_update: got op=%h a=%h go=%0b want 0 00 0", opcode, data_a, go);
        else passed++;
        send_byte(8'h21);
        checks++;
        if ({opcode, data_a, data_b, go, rx_ready} !== {4'h3, 8'h5A, 8'h21, 1'b1, 1'b0})
            $display("FAIL exec_operands: got op=%h a=%h b=%h go=%0b rdy=%0b want 3 5a 21 1 0", opcode, data_a, data_b, go, rx_ready);
        else passed++;
        n = 0;
        while (go && n < 100) begin tick(); n++; end
        checks++;
        if (n !== 4) $display("FAIL exec_go_width: got %0d cycles want 4", n);
        else passed++;
        while (!result_valid && n < 300) begin tick(); n++; end
        checks++;
        if (n !== 68) $display("FAIL exec_latency: got %0d cycles want 68", n);
        else passed++;
        checks++;
        if (result !== 8'h7B) $display("FAIL exec_result: got %h want 7b", result);
        else passed++;
        proc_data_out = 8'hEE;
        rx_byte  = 8'h00;
        rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if ({result_valid, result, rx_ready, busy} !== {1'b1, 8'h7B, 1'b0, 1'b1})
            $display("FAIL result_hold: got rv=%0b res=%h rdy=%0b busy=%0b want 1 7b 0 1", result_valid, result, rx_ready, busy);
        else passed++;
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        checks++;
        if ({result_valid, result, rx_ready, busy} !== {1'b0, 8'h7B, 1'b1, 1'b0})
            $display("FAIL result_ack: got rv=%0b res=%h rdy=%0b busy=%0b want 0 7b 1 0", result_valid, result, rx_ready, busy);
        else passed++;
        tick();
        rx_valid = 1'b0;
        checks++;
        if ({busy, rx_ready} !== 2'b11) $display("FAIL backpressure_consume: got busy=%0b rdy=%0b want 1 1", busy, rx_ready);
        else passed++;
    endtask

    // Finishes the frame opened by the stalled 0x00 header; ACK is held high before RESULT is reached.
    task automatic test_back_to_back();
        int n;
        proc_data_out = 8'h3C;
        send_byte(8'h10);
        send_byte(8'h20);
        result_ack = 1'b1;
        checks++;
        if ({opcode, data_a, data_b} !== {4'h0, 8'h10, 8'h20}) $display("FAIL b2b_operands: got op=%h a=%h b=%h want 0 10 20", opcode, data_a, data_b);
        else passed++;
        n = 0;
        while (!result_valid && n < 300) begin tick(); n++; end
        checks++;
        if ({n, result} !== {32'd68, 8'h3C}) $display("FAIL b2b_latency_result: got %0d cycles res=%h want 68 3c", n, result);
        else passed++;
        tick();
        result_ack = 1'b0;
        checks++;
        if ({result_valid, busy, result} !== {1'b0, 1'b0, 8'h3C}) $display("FAIL ack_early: got rv=%0b busy=%0b res=%h want 0 0 3c", result_valid, busy, result);
        else passed++;
    endtask

    task automatic test_jam_reset();
        int n;
        int bad;
        bad = 0;
        send_byte(8'h40);
        checks++;
        if ({jam, proc_reset, busy, rx_ready} !== 4'b1010) $display("FAIL jam_start: got jam=%0b prst=%0b busy=%0b rdy=%0b want 1 0 1 0", jam, proc_reset, busy, rx_ready);
        else passed++;
        n = 0;
        while (jam && n < 50) begin
            if (proc_reset || result_valid) bad++;
            tick();
            n++;
        end
        checks++;
        if (n !== 2) $display("FAIL jam_width: got %0d cycles want 2", n);
        else passed++;
        send_byte(8'h80);
        n = 0;
        while (proc_reset && n < 50) begin
            if (jam || result_valid) bad++;
            tick();
            n++;
        end
        checks++;
        if (n !== 2) $display("FAIL prst_width: got %0d cycles want 2", n);
        else passed++;
        checks++;
        if (bad !== 0) $display("FAIL pulse_exclusive: got %0d bad cycles want 0", bad);
        else passed++;
        checks++;
        if ({opcode, data_a, data_b, result_valid, busy} !== {4'h0, 8'h10, 8'h20, 1'b0, 1'b0})
            $display("FAIL pulse_no_side_effect: got op=%h a=%h b=%h rv=%0b busy=%0b want 0 10 20 0 0", opcode, data_a, data_b, result_valid, busy);
        else passed++;
    endtask

    task automatic test_illegal();
        int n;
        send_byte(8'hC5);
        checks++;
        if ({frame_err, busy, rx_ready} !== 3'b101) $display("FAIL illegal_err: got ferr=%0b busy=%0b rdy=%0b want 1 0 1", frame_err, busy, rx_ready);
        else passed++;
        tick();
        checks++;
        if ({frame_err, busy, opcode} !== {1'b0, 1'b0, 4'h0}) $display("FAIL illegal_pulse_end: got ferr=%0b busy=%0b op=%h want 0 0 0", frame_err, busy, opcode);
        else passed++;
        proc_data_out = 8'hA5;
        send_byte(8'h07);
        send_byte(8'hFF);
        send_byte(8'h01);
        n = 0;
        while (!result_valid && n < 300) begin tick(); n++; end
        checks++;
        if ({opcode, data_a, data_b, n, result} !== {4'h7, 8'hFF, 8'h01, 32'd68, 8'hA5})
            $display("FAIL after_illegal: got op=%h a=%h b=%h lat=%0d res=%h want 7 ff 01 68 a5", opcode, data_a, data_b, n, result);
        else passed++;
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
    endtask

    task automatic test_reset_abort();
        int n;
        send_byte(8'h02);
        send_byte(8'h33);
        send_byte(8'h44);
        tick();
        checks++;
        if (go !== 1'b1) $display("FAIL abort_go_before: got %0b want 1", go);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rx_ready, opcode, data_a, data_b, go, jam, proc_reset, result, result_valid, busy, frame_err} !== 35'd0)
            $display("FAIL abort_async: got go=%0b op=%h a=%h b=%h res=%h busy=%0b want all 0", go, opcode, data_a, data_b, result, busy);
        else passed++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        proc_data_out = 8'h5E;
        send_byte(8'h09);
        send_byte(8'h12);
        send_byte(8'h34);
        n = 0;
        while (!result_valid && n < 300) begin tick(); n++; end
        checks++;
        if ({opcode, data_a, data_b, n, result} !== {4'h9, 8'h12, 8'h34, 32'd68, 8'h5E})
            $display("FAIL abort_fresh_frame: got op=%h a=%h b=%h lat=%0d res=%h want 9 12 34 68 5e", opcode, data_a, data_b, n, result);
        else passed++;
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        checks++;
        if ({result_valid, busy} !== 2'b00) $display("FAIL abort_fresh_ack: got rv=%0b busy=%0b want 0 0", result_valid, busy);
        else passed++;
    endtask

`ifdef FRAME_TIMEOUT_EN
    task automatic test_frame_timeout();
        int n;
        send_byte(8'h06);
        n = 0;
        while (!frame_err && n < 100) begin tick(); n++; end
        checks++;
        if ({n, busy, opcode} !== {32'd10, 1'b0, 4'h9}) $display("FAIL timeout: got %0d cycles busy=%0b op=%h want 10 0 9", n, busy, opcode);
        else passed++;
        tick();
        checks++;
        if (frame_err !== 1'b0) $display("FAIL timeout_pulse: got %0b want 0", frame_err);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_execute_backpressure();
        test_back_to_back();
        test_jam_reset();
        test_illegal();
        test_reset_abort();
`ifdef FRAME_TIMEOUT_EN
        test_frame_timeout();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
